// File: rtl/traffic_light_fsm.sv
// rtl/traffic_light_fsm.sv - main/side street traffic light controller with pedestrian walk phase
module traffic_light_fsm #(
    parameter int TICK_DIV = 100000000
) (
    input  logic       clk,
    input  logic       systemReset_n,
    input  logic       reprogram,
    input  logic       sensor,
    input  logic       walk_request,
    input  logic [3:0] value,
    output logic [1:0] interval,
    output logic [2:0] mainLight,
    output logic [2:0] sideLight,
    output logic       walkLamp
);

    localparam int DW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        S_MG1  = 3'd0,
        S_MG2  = 3'd1,
        S_MY   = 3'd2,
        S_WALK = 3'd3,
        S_SG1  = 3'd4,
        S_SG2  = 3'd5,
        S_SY   = 3'd6
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] div_q;
    logic [3:0]    cnt_q;
    logic          load_q;
    logic          ext_q;
    logic          walk_q;
    logic          tick;
    logic          expire;
    logic          enter_walk;

    assign tick       = (div_q == DIV_LAST);
    assign expire     = !load_q && tick && (cnt_q == 4'd1);
    assign enter_walk = (state_d == S_WALK) && (state_q != S_WALK);

    always_ff @(posedge clk or negedge systemReset_n) begin
        if (!systemReset_n) begin
            state_q <= S_MG1;
            div_q   <= '0;
            cnt_q   <= '0;
            load_q  <= 1'b1;
            ext_q   <= 1'b0;
            walk_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= (reprogram || tick) ? '0 : div_q + 1'b1;
            load_q  <= reprogram || expire;
            walk_q  <= walk_request || (walk_q && !enter_walk);
            if (!reprogram) begin
                if (load_q) begin
                    cnt_q <= (value == 4'd0) ? 4'd1 : value;
                end else if (tick && (cnt_q > 4'd1)) begin
                    cnt_q <= cnt_q - 4'd1;
                end
            end
            // Extension choice is frozen at entry so the interval output stays purely registered
            if (!reprogram && expire && (state_d == S_MG2 || state_d == S_SG2)) begin
                ext_q <= sensor;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        if (expire) begin
            case (state_q)
                S_MG1:   state_d = S_MG2;
                S_MG2:   state_d = S_MY;
                S_MY:    state_d = walk_q ? S_WALK : S_SG1;
                S_WALK:  state_d = S_SG1;
                S_SG1:   state_d = S_SG2;
                S_SG2:   state_d = S_SY;
                S_SY:    state_d = S_MG1;
                default: state_d = S_MG1;
            endcase
        end
        if (reprogram) begin
            state_d = S_MG1;
        end
    end

    always_comb begin
        interval  = 2'b00;
        mainLight = 3'b100;
        sideLight = 3'b100;
        walkLamp  = 1'b0;
        case (state_q)
            S_MG1: begin
                mainLight = 3'b001;
            end
            S_MG2: begin
                mainLight = 3'b001;
                interval  = ext_q ? 2'b01 : 2'b00;
            end
            S_MY: begin
                mainLight = 3'b010;
                interval  = 2'b10;
            end
            S_WALK: begin
                interval = 2'b11;
                walkLamp = 1'b1;
            end
            S_SG1: begin
                sideLight = 3'b001;
            end
            S_SG2: begin
                sideLight = 3'b001;
                interval  = ext_q ? 2'b01 : 2'b00;
            end
            S_SY: begin
                sideLight = 3'b010;
                interval  = 2'b10;
            end
            default: begin
                mainLight = 3'b001;
            end
        endcase
    end

endmodule

// File: doc/traffic_light_fsm.md
TRAFFIC_LIGHT_FSM -- requirements
Module: traffic_light_fsm

Interface
REQ-001 Parameter TICK_DIV, default 100000000, clock cycles per 1-second tick (min 2).
REQ-002 clk  input  1  system clock, all state updates on rising edge.
REQ-003 systemReset_n  input  1  asynchronous, active-low reset.
REQ-004 reprogram  input  1  level-high pulse, the same strobe that writes the time-parameter store.
REQ-005 sensor  input  1  side-street vehicle present.
REQ-006 walk_request  input  1  pedestrian button, single-cycle pulse or level.
REQ-007 value  input  4  unsigned seconds returned by the time-parameter store for the current interval.
REQ-008 interval  output  2  selector to the time-parameter store: 00 tBASE, 01 tEXT, 10 tYEL, 11 tWALK.
REQ-009 mainLight  output  3  one-hot {red,yellow,green} for main street.
REQ-010 sideLight  output  3  one-hot {red,yellow,green} for side street.
REQ-011 walkLamp  output  1  pedestrian walk lamp.

Function
REQ-012 Tick divider SHALL count 0..TICK_DIV-1 and wrap to 0, asserting an internal tick for one cycle at the wrap.
REQ-013 States and interval driven: MG1 (00), MG2 (00 or 01), MY (10), WALK (11), SG1 (00), SG2 (00 or 01), SY (10).
REQ-014 MG2 and SG2 SHALL drive 01 when sensor was 1 on the cycle of entry, else 00; the choice holds for the whole state.
REQ-015 Order: MG1->MG2->MY->(WALK if walk pending)->SG1->SG2->SY->MG1.
REQ-016 Lamps: MG1/MG2 main=001 side=100; MY main=010 side=100; WALK main=100 side=100 walkLamp=1; SG1/SG2 main=100 side=001; SY main=100 side=010; walkLamp=0 outside WALK.
REQ-017 Lamps and interval SHALL be decoded from the state register only (Moore), no input-to-output combinational path.
REQ-018 First cycle in each state is a load cycle: at its closing edge the countdown register loads value (value 0 loads 1); ticks in the load cycle are ignored.
REQ-019 After load, each tick with countdown>1 SHALL decrement it; a tick with countdown==1 SHALL be expiry and advance the state at that edge.
REQ-020 State residency SHALL therefore be value ticks (1 for value 0), plus at most one cycle for the load.
REQ-021 walk_request SHALL set a sticky walk-pending flag in any state; entering WALK clears it; a request during WALK sets it for the next cycle.
REQ-022 reprogram==1 SHALL force MG1 next edge, clear the tick divider, and restart the load cycle; walk-pending is kept; reprogram overrides expiry in the same cycle.
REQ-023 value changes mid-state (after load) SHALL NOT affect the running countdown.

Reset
REQ-024 systemReset_n low SHALL immediately (asynchronously) force MG1, interval=00, mainLight=001, sideLight=100, walkLamp=0, divider=0, countdown=0, walk-pending=0, load cycle pending.
REQ-025 Reset assertion mid-state SHALL abandon the countdown; first edge after release is a load cycle of MG1.

Verification (TICK_DIV=4; value stub: 00->6, 01->3, 10->2, 11->3)
REQ-026 Release reset, sensor=0, no walk -> MG1 6 ticks, MG2 6, MY 2, SG1 6, SG2 6, SY 2, back to MG1; lamps per REQ-016.
REQ-027 sensor=1 held -> MG2 and SG2 drive interval=01 and last 3 ticks each.
REQ-028 walk_request pulse during MG1 -> after MY, WALK with walkLamp=1, main=side=100 for 3 ticks, then SG1; next cycle with no request skips WALK.
REQ-029 reprogram pulse in SG2 -> next edge MG1, main=001, full 6-tick MG1 follows.
REQ-030 Stub returns 0 for interval 10 -> MY and SY each last exactly 1 tick.
REQ-031 systemReset_n low mid-SY, asynchronously between edges -> outputs match REQ-024 before next clk edge; normal sequence resumes after release.
